// File: rtl/bids22_round_seq_if.sv
// Bundles the control-sequencer command inputs and the auction control/status signals.
// slave is the sequencer side, master is the side that drives go and reads the results.
interface bids22_round_seq_if;
    logic        go;
    logic [31:0] bal_x;
    logic [31:0] bal_y;
    logic [31:0] bal_z;
    logic [31:0] lock_key;
    logic [15:0] round_len;
    logic [2:0]  err;
    logic        roundOver;
    logic        X_win;
    logic        Y_win;
    logic        Z_win;
    logic [31:0] maxBid;
    logic [3:0]  C_op;
    logic [31:0] C_data;
    logic        C_start;
    logic        busy;
    logic        done;
    logic        fail;
    logic [2:0]  fail_code;
    logic [1:0]  winner;
    logic [31:0] win_amt;

    modport slave (
        input  go, bal_x, bal_y, bal_z, lock_key, round_len,
        input  err, roundOver, X_win, Y_win, Z_win, maxBid,
        output C_op, C_data, C_start, busy, done, fail, fail_code, winner, win_amt
    );

    modport master (
        output go, bal_x, bal_y, bal_z, lock_key, round_len,
        output err, roundOver, X_win, Y_win, Z_win, maxBid,
        input  C_op, C_data, C_start, busy, done, fail, fail_code, winner, win_amt
    );
endinterface

// File: rtl/bids22_round_seq.sv
// Auction round sequencer: unlock, load three balances, lock, run one timed round,
// then wait (bounded) for the round result and report winner or failure.
module bids22_round_seq (
    input  logic              clk,
    input  logic              reset_n,
    bids22_round_seq_if.slave bus
);
    typedef enum logic [3:0] {
        S_IDLE, S_UNLOCK, S_LOAD_X, S_LOAD_Y, S_LOAD_Z,
        S_LOCK, S_CHK, S_RUN, S_WAIT, S_DONE, S_FAIL
    } state_t;

    localparam logic [9:0] WAIT_LAST = 10'd1022;

    state_t      state_q, state_d;
    logic [31:0] bal_x_q, bal_x_d;
    logic [31:0] bal_y_q, bal_y_d;
    logic [31:0] bal_z_q, bal_z_d;
    logic [31:0] key_q, key_d;
    logic [15:0] len_q, len_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [9:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  fail_code_q, fail_code_d;
    logic [1:0]  winner_q, winner_d;
    logic [31:0] win_amt_q, win_amt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            bal_x_q     <= '0;
            bal_y_q     <= '0;
            bal_z_q     <= '0;
            key_q       <= '0;
            len_q       <= '0;
            run_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            fail_code_q <= '0;
            winner_q    <= '0;
            win_amt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bal_x_q     <= bal_x_d;
            bal_y_q     <= bal_y_d;
            bal_z_q     <= bal_z_d;
            key_q       <= key_d;
            len_q       <= len_d;
            run_cnt_q   <= run_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            fail_code_q <= fail_code_d;
            winner_q    <= winner_d;
            win_amt_q   <= win_amt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bal_x_d     = bal_x_q;
        bal_y_d     = bal_y_q;
        bal_z_d     = bal_z_q;
        key_d       = key_q;
        len_d       = len_q;
        run_cnt_d   = run_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        fail_code_d = fail_code_q;
        winner_d    = winner_q;
        win_amt_d   = win_amt_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d     = S_UNLOCK;
                    bal_x_d     = bus.bal_x;
                    bal_y_d     = bus.bal_y;
                    bal_z_d     = bus.bal_z;
                    key_d       = bus.lock_key;
                    len_d       = bus.round_len;
                    fail_code_d = '0;
                    winner_d    = '0;
                    win_amt_d   = '0;
                end
            end
            S_UNLOCK: state_d = S_LOAD_X;
            S_LOAD_X: state_d = S_LOAD_Y;
            S_LOAD_Y, S_LOAD_Z, S_LOCK, S_CHK: begin
                if (bus.err != 3'd0) begin
                    state_d     = S_FAIL;
                    fail_code_d = bus.err;
                end else begin
                    unique case (state_q)
                        S_LOAD_Y: state_d = S_LOAD_Z;
                        S_LOAD_Z: state_d = S_LOCK;
                        S_LOCK:   state_d = S_CHK;
                        default: begin
                            state_d   = S_RUN;
                            // a zero length still gives a one-cycle round
                            run_cnt_d = (len_q == 16'd0) ? 16'd1 : len_q;
                        end
                    endcase
                end
            end
            S_RUN: begin
                if (run_cnt_q == 16'd1) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q - 16'd1;
                end
            end
            S_WAIT: begin
                // roundOver wins over the timeout on the final wait cycle
                if (bus.roundOver) begin
                    state_d   = S_DONE;
                    win_amt_d = bus.maxBid;
                    if (bus.X_win)      winner_d = 2'd1;
                    else if (bus.Y_win) winner_d = 2'd2;
                    else if (bus.Z_win) winner_d = 2'd3;
                    else                winner_d = 2'd0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = S_FAIL;
                    fail_code_d = 3'b111;
                end else begin
                    wait_cnt_d = wait_cnt_q + 10'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.C_op    = 4'h0;
        bus.C_data  = 32'h0;
        bus.C_start = 1'b0;
        bus.busy    = (state_q != S_IDLE);
        bus.done    = (state_q == S_DONE);
        bus.fail    = (state_q == S_FAIL);
        unique case (state_q)
            S_UNLOCK: bus.C_op = 4'h1;
            S_LOAD_X: begin bus.C_op = 4'h3; bus.C_data = bal_x_q; end
            S_LOAD_Y: begin bus.C_op = 4'h4; bus.C_data = bal_y_q; end
            S_LOAD_Z: begin bus.C_op = 4'h5; bus.C_data = bal_z_q; end
            S_LOCK:   begin bus.C_op = 4'h2; bus.C_data = key_q;   end
            S_RUN:    bus.C_start = 1'b1;
            default:  ;
        endcase
    end

    assign bus.fail_code = fail_code_q;
    assign bus.winner    = winner_q;
    assign bus.win_amt   = win_amt_q;
endmodule

// File: doc/bids22_round_seq.md
BIDS22_ROUND_SEQ -- requirements
Module: bids22_round_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 reset_n  in  1  asynchronous active-low reset.
REQ-004 go  in  1  start-sequence pulse; sampled only in IDLE.
REQ-005 bal_x, bal_y, bal_z  in  32 each  balance words for X/Y/Z, sampled at go acceptance.
REQ-006 lock_key  in  32  lock-op data word, sampled at go acceptance.
REQ-007 round_len  in  16  C_start high-time in cycles, sampled at go acceptance.
REQ-008 err  in  3  auction error code.
REQ-009 roundOver  in  1  auction round-complete flag.
REQ-010 X_win, Y_win, Z_win  in  1 each  auction winner flags.
REQ-011 maxBid  in  32  auction winning amount.
REQ-012 C_op  out  4  auction control opcode.
REQ-013 C_data  out  32  auction control data.
REQ-014 C_start  out  1  auction round enable.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle success pulse.
REQ-017 fail  out  1  one-cycle failure pulse.
REQ-018 fail_code  out  3  failure cause; held until next accepted go.
REQ-019 winner  out  2  0 none, 1 X, 2 Y, 3 Z; held until next accepted go.
REQ-020 win_amt  out  32  captured maxBid; held until next accepted go.

Function
REQ-021 The block SHALL be a Moore FSM: IDLE, UNLOCK, LOAD_X, LOAD_Y, LOAD_Z, LOCK, CHK, RUN, WAIT, DONE, FAIL; C_op/C_data/C_start/busy/done/fail decode from the state register only.
REQ-022 Opcodes SHALL be: UNLOCK C_op=4'h1, C_data=0; LOAD_X 4'h3/bal_x; LOAD_Y 4'h4/bal_y; LOAD_Z 4'h5/bal_z; LOCK 4'h2/lock_key; all other states C_op=0, C_data=0.
REQ-023 go=1 in IDLE at edge t SHALL capture the inputs of REQ-005..007, clear winner/win_amt/fail_code, and enter UNLOCK at t+1; LOAD_X t+2, LOAD_Y t+3, LOAD_Z t+4, LOCK t+5, CHK t+6, RUN t+7.
REQ-024 go outside IDLE SHALL be ignored.
REQ-025 Each of UNLOCK..LOCK SHALL last exactly one cycle.
REQ-026 err SHALL be ignored in UNLOCK and LOAD_X; in LOAD_Y, LOAD_Z, LOCK and CHK, err!=0 SHALL go to FAIL next cycle with fail_code=err.
REQ-027 RUN SHALL hold C_start=1 for exactly max(round_len,1) cycles via a 16-bit down-counter, then go to WAIT.
REQ-028 WAIT SHALL hold C_start=0 and count cycles in a 10-bit counter cleared on WAIT entry.
REQ-029 roundOver=1 in WAIT SHALL capture win_amt=maxBid and winner (priority X>Y>Z, none=0), then go to DONE.
REQ-030 1023 WAIT cycles without roundOver SHALL go to FAIL with fail_code=3'b111; roundOver on cycle 1023 SHALL take precedence over timeout.
REQ-031 DONE and FAIL SHALL last one cycle, assert done or fail, then return to IDLE.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, all outputs 0, and all counters and captured registers to 0, including mid-sequence.
REQ-033 Sampled inputs SHALL be taken only on the first rising edge after reset_n deasserts.

Verification
REQ-034 go with bal_x=0x10000, bal_y=0x20000, bal_z=0x30000, lock_key=0x790, round_len=4, err=0 -> C_op 1,3,4,5,2 on t+1..t+5, C_start=1 t+7..t+10; roundOver with Y_win=1, maxBid=0x55 at t+13 -> done at t+14, winner=2, win_amt=0x55.
REQ-035 err=3'b010 during LOAD_Z -> fail pulse next cycle, fail_code=2, C_start never asserted.
REQ-036 round_len=0 -> C_start high exactly 1 cycle; no roundOver -> fail after 1023 WAIT cycles, fail_code=7.
REQ-037 reset_n=0 during RUN -> C_start, busy and C_op 0 asynchronously; IDLE after release; next go restarts at UNLOCK.
REQ-038 go re-pulsed during RUN, and X_win=Z_win=1 at roundOver -> go ignored, winner=1.
